// File: rtl/aux_in_cond.sv
// aux_in_cond: auxiliary GPIO input conditioner.
//
// Each input bit is synchronised through a SYNC_STAGES-deep flop chain and
// then glitch-filtered: a new level is accepted only after it has been seen
// for filt_len+1 consecutive cycles. Accepted rising/falling edges set
// sticky write-1-to-clear status bits, which are masked and OR-ed into irq.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      asynchronous active-high reset
//   aux_in       raw asynchronous inputs (sampled only by the first sync stage)
//   filt_len     extra stable cycles before a level change is accepted
//   irq_rise_en  per-bit enable: accepted 0->1 sets status
//   irq_fall_en  per-bit enable: accepted 1->0 sets status
//   irq_mask     per-bit mask of status into irq
//   irq_clr      one-cycle write-1-to-clear pulses for irq_status
//   aux_i        filtered, synchronised input level
//   irq_status   sticky per-bit edge-event flags
//   irq          OR of (irq_status & irq_mask)
//
// SYNC_STAGES must be at least 2.

module aux_in_cond #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_BITS   = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [WIDTH-1:0]     aux_in,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic [WIDTH-1:0]     irq_rise_en,
  input  logic [WIDTH-1:0]     irq_fall_en,
  input  logic [WIDTH-1:0]     irq_mask,
  input  logic [WIDTH-1:0]     irq_clr,
  output logic [WIDTH-1:0]     aux_i,
  output logic [WIDTH-1:0]     irq_status,
  output logic                 irq
);

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     s;
  logic [FILT_BITS-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0]     level_q;
  logic [WIDTH-1:0]     status_q;
  logic [WIDTH-1:0]     update;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;

  // Synchroniser chain; stage 0 is the only flop that sees aux_in.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= aux_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ">=" rather than "==" so that shrinking filt_len mid-count forces the
  // update on the next edge instead of letting cnt run past filt_len.
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (s[i] != level_q[i]) && (cnt_q[i] >= filt_len);
    end
  end

  // Events use the pre-update sampled level: on an update s is the new level.
  assign rise = update & s & irq_rise_en;
  assign fall = update & ~s & irq_fall_en;

  // Filter counters and accepted level. cnt only increments while below
  // filt_len, so it can never wrap.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (update[i]) begin
          level_q[i] <= s[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + FILT_BITS'(1);
        end
      end
    end
  end

  // Sticky status; a new event on the same edge as a clear wins.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~irq_clr) | rise | fall;
    end
  end

  assign aux_i      = level_q;
  assign irq_status = status_q;
  assign irq        = |(status_q & irq_mask);

endmodule

// File: tb/tb_aux_in_cond.sv
// Self-checking bench for aux_in_cond (WIDTH=8, SYNC_STAGES=2, FILT_BITS=4).
// Directed table, hand-written corner sequences, then randomized stimulus,
// all cross-checked every cycle against a behavioural model.

module tb_aux_in_cond;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int FB = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [W-1:0]  aux_in = '0;
  logic [FB-1:0] filt_len = '0;
  logic [W-1:0]  irq_rise_en = '0;
  logic [W-1:0]  irq_fall_en = '0;
  logic [W-1:0]  irq_mask = '0;
  logic [W-1:0]  irq_clr = '0;
  logic [W-1:0]  aux_i;
  logic [W-1:0]  irq_status;
  logic          irq;

  aux_in_cond #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_BITS(FB)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .aux_in     (aux_in),
    .filt_len   (filt_len),
    .irq_rise_en(irq_rise_en),
    .irq_fall_en(irq_fall_en),
    .irq_mask   (irq_mask),
    .irq_clr    (irq_clr),
    .aux_i      (aux_i),
    .irq_status (irq_status),
    .irq        (irq)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the sampled level is the aux_in value seen SS edges
  // earlier (a queue of samples); a bit's accepted level flips once the
  // sampled level has disagreed with it for filt_len+1 consecutive edges.
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_level;
  logic [W-1:0] m_status;
  int           m_run [W];

  function automatic void model_reset();
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
    m_level  = '0;
    m_status = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endfunction

  function automatic void model_step();
    logic [W-1:0] samp;
    logic [W-1:0] ev;
    samp = m_hist[0];
    ev   = '0;
    for (int i = 0; i < W; i++) begin
      if (samp[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > int'(filt_len)) begin
          m_level[i] = samp[i];
          m_run[i]   = 0;
          if (samp[i] && irq_rise_en[i]) ev[i] = 1'b1;
          if (!samp[i] && irq_fall_en[i]) ev[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_status = (m_status & ~irq_clr) | ev;
    void'(m_hist.pop_front());
    m_hist.push_back(aux_in);
  endfunction

  task automatic compare_model();
    check("model_aux_i", aux_i, m_level);
    check("model_irq_status", irq_status, m_status);
    check("model_irq", {7'b0, irq}, {7'b0, |(m_status & irq_mask)});
  endtask

  // One clock: model advances on the active edge, DUT sampled on the falling edge.
  task automatic step();
    @(posedge sys_clk);
    if (sys_rst) model_reset();
    else model_step();
    @(negedge sys_clk);
    compare_model();
  endtask

  typedef struct {
    logic [W-1:0]  aux;
    logic [FB-1:0] fl;
    logic [W-1:0]  re;
    logic [W-1:0]  fe;
    logic [W-1:0]  mk;
    logic [W-1:0]  clr;
    logic [W-1:0]  e_aux;
    logic [W-1:0]  e_st;
    logic          e_irq;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //             aux    fl    re     fe     mk     clr    e_aux  e_st   e_irq
    tbl[0]  = '{8'hFF, 4'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'hFF, 4'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'hFF, 4'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0};
    tbl[3]  = '{8'hFF, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
    tbl[4]  = '{8'hFF, 4'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[5]  = '{8'h00, 4'd0, 8'h01, 8'h02, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    tbl[6]  = '{8'h00, 4'd0, 8'h01, 8'h02, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    tbl[7]  = '{8'h00, 4'd0, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[8]  = '{8'h03, 4'd0, 8'h01, 8'h02, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h03, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{8'h03, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 1'b0};
    tbl[11] = '{8'h04, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 1'b0};
    tbl[12] = '{8'h04, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 1'b0};
    tbl[13] = '{8'h04, 4'd0, 8'h01, 8'h02, 8'h00, 8'h00, 8'h04, 8'h03, 1'b0};
    tbl[14] = '{8'h04, 4'd0, 8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'h00, 1'b0};

    model_reset();

    // Reset held with inputs high: everything stays 0.
    aux_in = 8'hFF;
    irq_rise_en = 8'hFF;
    irq_mask = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_aux_i", aux_i, 8'h00);
      check("reset_status", irq_status, 8'h00);
      check("reset_irq", {7'b0, irq}, 8'h00);
    end

    // Directed table, one row per clock.
    sys_rst = 1'b0;
    for (int r = 0; r < 15; r++) begin
      aux_in = tbl[r].aux;  filt_len = tbl[r].fl;
      irq_rise_en = tbl[r].re;  irq_fall_en = tbl[r].fe;
      irq_mask = tbl[r].mk;  irq_clr = tbl[r].clr;
      step();
      check($sformatf("tbl%0d_aux_i", r), aux_i, tbl[r].e_aux);
      check($sformatf("tbl%0d_status", r), irq_status, tbl[r].e_st);
      check($sformatf("tbl%0d_irq", r), {7'b0, irq}, {7'b0, tbl[r].e_irq});
    end
    irq_clr = '0;

    // Mask is combinational; clear takes effect on the sampled edge.
    aux_in = 8'h05;
    for (int k = 0; k < 3; k++) step();
    check("mask_status", irq_status, 8'h01);
    check("mask_off_irq", {7'b0, irq}, 8'h00);
    irq_mask = 8'h01;
    #1;
    check("mask_on_irq", {7'b0, irq}, 8'h01);
    irq_clr = 8'h01;
    step();
    irq_clr = '0;
    check("clr_status", irq_status, 8'h00);
    check("clr_irq", {7'b0, irq}, 8'h00);

    // Glitch of 3 sampled cycles with filt_len=3 is rejected.
    aux_in = 8'h00;
    for (int k = 0; k < 4; k++) step();
    filt_len = 4'd3;
    aux_in = 8'h01;
    for (int k = 0; k < 3; k++) step();
    aux_in = 8'h00;
    for (int k = 0; k < 6; k++) begin
      step();
      check("glitch_aux_i", aux_i, 8'h00);
      check("glitch_status", irq_status, 8'h00);
    end
    // Held for 4: accepted at edge 6.
    aux_in = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("accept_e5_aux_i", aux_i, 8'h00);
    end
    check("accept_e6_aux_i", aux_i, 8'h01);
    check("accept_e6_status", irq_status, 8'h01);

    // Set/clear collision: set wins.
    irq_clr = 8'h01;
    step();
    irq_clr = '0;
    filt_len = 4'd0;
    aux_in = 8'h00;
    for (int k = 0; k < 4; k++) step();
    check("pre_collide_status", irq_status, 8'h00);
    aux_in = 8'h01;
    step();
    step();
    irq_clr = 8'h01;
    step();
    irq_clr = '0;
    check("collide_status", irq_status, 8'h01);

    // Asynchronous reset in the middle of a filter count.
    irq_clr = 8'hFF;
    step();
    irq_clr = '0;
    irq_rise_en = 8'h08;
    filt_len = 4'd7;
    aux_in = 8'h09;
    for (int k = 0; k < 6; k++) step();
    #2;
    sys_rst = 1'b1;
    model_reset();
    #1;
    check("midrst_aux_i", aux_i, 8'h00);
    check("midrst_status", irq_status, 8'h00);
    @(negedge sys_clk);
    step();
    sys_rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) check("postrst_e9_aux_i", aux_i, 8'h00);
    end
    check("postrst_e10_aux_i", aux_i, 8'h09);
    check("postrst_e10_status", irq_status, 8'h08);

    // filt_len shrink mid-count forces the update on the next edge.
    irq_clr = 8'hFF;
    irq_fall_en = 8'h01;
    aux_in = 8'h08;
    step();
    irq_clr = '0;
    for (int k = 2; k <= 7; k++) step();
    check("shrink_before_aux_i", aux_i, 8'h09);
    filt_len = 4'd2;
    step();
    check("shrink_after_aux_i", aux_i, 8'h08);
    check("shrink_after_status", irq_status, 8'h01);

    // Randomized stimulus against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) filt_len = FB'($urandom_range(0, 3));
      if (c % 25 == 0) begin
        irq_rise_en = W'($urandom);
        irq_fall_en = W'($urandom);
      end
      if ($urandom_range(0, 3) == 0) aux_in = aux_in ^ W'(1 << $urandom_range(0, W-1));
      irq_mask = W'($urandom);
      irq_clr  = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aux_in_cond.md
# aux_in_cond

Parametrised GPIO auxiliary-input conditioner. It is the next generation of the plain registered aux input. Each of WIDTH input bits passes through a multi-stage synchroniser and a programmable-length glitch filter. Filtered rising and falling edges are detected per bit, latched into sticky write-1-to-clear status bits, and merged through a mask into a single interrupt line toward the GPIO register/interrupt block.

## Interface
- WIDTH, 32, number of input bits
- SYNC_STAGES, 2, synchroniser flops per bit (legal values ≥ 2)
- FILT_BITS, 4, width of the filter length and the per-bit stability counter
- sys_clk  input  1  system clock
- sys_rst  input  1  reset, asynchronous, active-high; clock sys_clk
- aux_in  input  WIDTH  raw asynchronous auxiliary inputs
- filt_len  input  FILT_BITS  extra stable cycles required before a level change is accepted; shared by all bits; quasi-static
- irq_rise_en  input  WIDTH  per bit: a filtered 0→1 transition sets status
- irq_fall_en  input  WIDTH  per bit: a filtered 1→0 transition sets status
- irq_mask  input  WIDTH  per bit: status contributes to irq when 1
- irq_clr  input  WIDTH  one-cycle write-1-to-clear pulses for irq_status
- aux_i  output  WIDTH  filtered, synchronised input level
- irq_status  output  WIDTH  sticky per-bit edge-event flags
- irq  output  1  OR of (irq_status & irq_mask)

## Operation
- **Synchroniser:** a SYNC_STAGES-deep flop chain per bit. The last stage is s[i].
- **Filter:** each bit keeps a counter cnt[i] (FILT_BITS wide) and an accepted level q[i]. q drives aux_i.
  - If s[i] == q[i]: cnt[i] ← 0.
  - If s[i] != q[i] and cnt[i] >= filt_len: q[i] ← s[i] and cnt[i] ← 0. This is the update event.
  - Otherwise: cnt[i] ← cnt[i] + 1.
  - A new level must persist for filt_len+1 consecutive s-cycles. Any return to q restarts the count.
  - filt_len = 0 means no filtering.
  - The compare is ">=". If filt_len drops below cnt in mid-count, the update happens on the next edge. cnt never wraps.
- **Edge events:** these are combinational from the pre-update values.
  - rise[i] = update & s[i] & irq_rise_en[i]
  - fall[i] = update & ~s[i] & irq_fall_en[i]
- **Status:** irq_status[i] ← (irq_status[i] & ~irq_clr[i]) | rise[i] | fall[i].
  - If set and clear occur on the same edge, set wins.
  - Enables gate only the setting of status. Disabling an enable does not clear status.
- **Interrupt:** irq = |(irq_status & irq_mask). It is combinational from registers and the mask; the mask does not affect status.
- **After reset:** q = 0. An input held high is accepted as a filtered rising edge after the normal latency, and sets status if irq_rise_en is 1. This is intentional: the reset state reads as "low".

## Timing
- **Reset values:** sync flops, cnt, aux_i, irq_status and irq are all 0.
- **Reset mid-operation:** sys_rst clears all state asynchronously. Any in-progress filter count is discarded.
- **Latency:** take an aux_in change that is stable before edge 1. aux_i and irq_status update at edge SYNC_STAGES + filt_len + 1. With defaults and filt_len = 0 that is edge 3.
- **irq timing:** irq changes in the same cycle as irq_status. It changes immediately when irq_mask changes.
- **irq_clr:** takes effect on the edge where it is sampled high, so status reads 0 in the following cycle unless an event occurs on that same edge.
- **Metastability:** only the first synchroniser stage samples aux_in. No other logic uses aux_in directly.

## Test plan
(WIDTH = 8, SYNC_STAGES = 2)
- **Reset and latency:** hold sys_rst high with aux_in = 8'hFF → all outputs 0. Release, filt_len = 0, rise_en = 8'hFF → aux_i = 8'hFF and irq_status = 8'hFF at edge 3. Assert sys_rst mid-filter (filt_len = 7, cnt = 4) → aux_i = 0 and cnt restarts after release.
- **Glitch rejection:** filt_len = 3, aux_in[0] high for 3 cycles then low → aux_i[0] stays 0 and status stays 0. Held high for 4 cycles → aux_i[0] = 1 at edge 6.
- **Edge selection:** rise_en = 8'h01, fall_en = 8'h02. Raise bits 0 and 1 → status = 8'h01. Lower both → status = 8'h03. Bit 2 toggled → no status.
- **Mask and clear:** status = 8'h01 with mask = 8'h00 → irq = 0. Set mask = 8'h01 → irq = 1 in the same cycle. irq_clr = 8'h01 for one cycle → status = 0 and irq = 0 on the next cycle.
- **Set/clear collision:** irq_clr[0] pulsed on the edge where rise[0] fires → irq_status[0] = 1.
- **filt_len shrink:** filt_len = 7, bit 0 differs with cnt = 5. Change filt_len to 2 → aux_i[0] updates on the next edge and status sets.
